// File: rtl/xorexec_pkg.sv
// Shared types and helpers for the multi-op packet reducer: opcode and FSM
// state encodings, header field positions and the reduction operators.
package xorexec_pkg;

    typedef enum logic [1:0] {
        OP_XOR = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_ADD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd2,
        ST_PUSH  = 3'd4
    } state_e;

    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 1;
    localparam int CNT_LSB = 2;

    // Helpers work on a wide word; callers zero-extend in and truncate out,
    // which keeps ADD modulo 2^DWIDTH for any DWIDTH up to MAX_W.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t identity(input op_e op);
        return (op == OP_AND) ? '1 : '0;
    endfunction

    function automatic word_t apply(input op_e op, input word_t a, input word_t b);
        case (op)
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            default: return a ^ b;
        endcase
    endfunction

endpackage

// File: rtl/xorexec_fifo.sv
// Synchronous FIFO with first-word fall-through head; a full push or an
// empty pop is ignored, and the head reads as zero while empty.
module xorexec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_full,
    output logic             not_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        not_full  = (count_q != (AW+1)'(DEPTH));
        not_empty = (count_q != '0);
        do_wr     = wr_en && not_full;
        do_rd     = rd_en && not_empty;
        wr_ptr_d  = wr_ptr_q + AW'(do_wr);
        rd_ptr_d  = rd_ptr_q + AW'(do_rd);
        count_d   = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        rd_data   = not_empty ? mem[rd_ptr_q] : '0;
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; stale entries are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/xorexec_multi.sv
// Packet reducer: header {N, op} then N operands in, one reduced result out,
// buffered on both sides by FWFT FIFOs.
module xorexec_multi
    import xorexec_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int IDEPTH = 8,
    parameter int ODEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ififo_push,
    output logic              ififo_not_full,
    input  logic [DWIDTH-1:0] idata,
    input  logic              ofifo_pop,
    output logic              ofifo_rdy,
    output logic [DWIDTH-1:0] odata,
    output logic [2:0]        exec_state,
    input  logic              err_clr,
    output logic              ovfl_err,
    output logic              udfl_err
);

    localparam int CW = DWIDTH - CNT_LSB;

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_ACCUM = ST_ACCUM;
    localparam logic [2:0] S_PUSH  = ST_PUSH;

    logic [DWIDTH-1:0] in_data;
    logic              in_ne, in_pop;
    logic              out_nf, out_wr;
    op_e               hdr_op;
    logic [CW-1:0]     hdr_cnt;

    logic [2:0]        state_q, state_d;
    op_e               op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic              ovfl_q, ovfl_d;
    logic              udfl_q, udfl_d;

    xorexec_fifo #(.WIDTH(DWIDTH), .DEPTH(IDEPTH)) u_ififo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (ififo_push),
        .wr_data   (idata),
        .rd_en     (in_pop),
        .rd_data   (in_data),
        .not_full  (ififo_not_full),
        .not_empty (in_ne)
    );

    xorexec_fifo #(.WIDTH(DWIDTH), .DEPTH(ODEPTH)) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (out_wr),
        .wr_data   (acc_q),
        .rd_en     (ofifo_pop),
        .rd_data   (odata),
        .not_full  (out_nf),
        .not_empty (ofifo_rdy)
    );

    assign hdr_op  = op_e'(in_data[OP_MSB:OP_LSB]);
    assign hdr_cnt = in_data[DWIDTH-1:CNT_LSB];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        in_pop  = 1'b0;
        out_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_ne) begin
                    in_pop  = 1'b1;
                    op_d    = hdr_op;
                    cnt_d   = hdr_cnt;
                    acc_d   = DWIDTH'(identity(hdr_op));
                    state_d = (hdr_cnt == '0) ? S_PUSH : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_ne) begin
                    in_pop = 1'b1;
                    acc_d  = DWIDTH'(apply(op_q, MAX_W'(acc_q), MAX_W'(in_data)));
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (out_nf) begin
                    out_wr  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr wins, so no event is lost.
    always_comb begin
        ovfl_d = (ovfl_q & ~err_clr) | (ififo_push & ~ififo_not_full);
        udfl_d = (udfl_q & ~err_clr) | (ofifo_pop & ~ofifo_rdy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_XOR;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovfl_q  <= 1'b0;
            udfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovfl_q  <= ovfl_d;
            udfl_q  <= udfl_d;
        end
    end

    assign exec_state = state_q;
    assign ovfl_err   = ovfl_q;
    assign udfl_err   = udfl_q;

endmodule

// File: tb/tb_xorexec_multi.sv
// Directed bench for xorexec_multi: expected results are queued as packets
// are sent and compared as the output FIFO is drained.
module tb_xorexec_multi;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ififo_push = 1'b0;
    logic          ififo_not_full;
    logic [DW-1:0] idata = '0;
    logic          ofifo_pop = 1'b0;
    logic          ofifo_rdy;
    logic [DW-1:0] odata;
    logic [2:0]    exec_state;
    logic          err_clr = 1'b0;
    logic          ovfl_err;
    logic          udfl_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    xorexec_multi #(.DWIDTH(DW), .IDEPTH(8), .ODEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ififo_push     (ififo_push),
        .ififo_not_full (ififo_not_full),
        .idata          (idata),
        .ofifo_pop      (ofifo_pop),
        .ofifo_rdy      (ofifo_rdy),
        .odata          (odata),
        .exec_state     (exec_state),
        .err_clr        (err_clr),
        .ovfl_err       (ovfl_err),
        .udfl_err       (udfl_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input int n, input int op);
        logic [DW-1:0] h;
        h = DW'((n << 2) | (op & 3));
        return h;
    endfunction

    // Called at a negedge: drive one word for the next rising edge.
    task automatic push_word(input logic [DW-1:0] w);
        ififo_push = 1'b1;
        idata      = w;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget;
        while (exp_q.size() > 0) begin
            budget = 0;
            while (!ofifo_rdy && budget < 60) begin
                @(negedge clk);
                budget++;
            end
            if (!ofifo_rdy) begin
                check({tag, "_timeout"}, ofifo_rdy, 1);
                exp_q.delete();
            end else begin
                check(tag, odata, exp_q.pop_front());
                ofifo_pop = 1'b1;
                @(negedge clk);
                ofifo_pop = 1'b0;
            end
        end
    endtask

    initial begin
        logic [2:0]    st_seq [6];
        logic [DW-1:0] ops [3];
        st_seq = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd4, 3'd0};
        ops    = '{8'h04, 8'h0F, 8'h30};

        // Reset values while rst is held
        @(negedge clk);
        check("rst_not_full", ififo_not_full, 1);
        check("rst_rdy", ofifo_rdy, 0);
        check("rst_odata", odata, 0);
        check("rst_state", exec_state, 0);
        check("rst_ovfl", ovfl_err, 0);
        check("rst_udfl", udfl_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // XOR of three operands: cycle-accurate state walk, result at cycle N+3
        exp_q.push_back(8'h3B);
        push_word(hdr(3, 0));
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("xor_state_c%0d", k), exec_state, st_seq[k-1]);
            check($sformatf("xor_rdy_c%0d", k), ofifo_rdy, (k == 6) ? 1 : 0);
            if (k <= 3) begin
                ififo_push = 1'b1;
                idata      = ops[k-1];
            end else begin
                ififo_push = 1'b0;
            end
            @(negedge clk);
        end
        drain("xor_result");

        // AND with N=0 yields the identity after a single PUSH cycle
        exp_q.push_back(8'hFF);
        push_word(hdr(0, 1));
        ififo_push = 1'b0;
        check("and0_state_idle", exec_state, 0);
        @(negedge clk);
        check("and0_state_push", exec_state, 4);
        @(negedge clk);
        check("and0_state_back", exec_state, 0);
        check("and0_rdy", ofifo_rdy, 1);
        drain("and0_result");

        // ADD wraps modulo 2^DW
        exp_q.push_back(8'h10);
        push_word(hdr(2, 3));
        push_word(8'hF0);
        push_word(8'h20);
        ififo_push = 1'b0;
        drain("add_wrap");

        // Five packets with no consumer: output fills, FSM stalls in PUSH
        for (int p = 1; p <= 5; p++) begin
            exp_q.push_back(DW'(p * 8'h11));
            push_word(hdr(1, 0));
            push_word(DW'(p * 8'h11));
        end
        ififo_push = 1'b0;
        repeat (30) @(negedge clk);
        check("stall_state", exec_state, 4);
        check("stall_rdy", ofifo_rdy, 1);
        check("stall_in_not_full", ififo_not_full, 1);

        // Fill the input FIFO while stalled; the ninth word must be dropped
        for (int p = 1; p <= 4; p++) begin
            exp_q.push_back(DW'(8'hA0 + p));
            push_word(hdr(1, 0));
            push_word(DW'(8'hA0 + p));
        end
        ififo_push = 1'b0;
        check("fill8_not_full", ififo_not_full, 0);
        check("fill8_ovfl", ovfl_err, 0);
        push_word(8'hEE);
        ififo_push = 1'b0;
        check("ovfl_not_full", ififo_not_full, 0);
        check("ovfl_set", ovfl_err, 1);

        // One pop frees a slot; the stalled result is written the cycle after
        check("stall_head", odata, exp_q.pop_front());
        ofifo_pop = 1'b1;
        @(negedge clk);
        ofifo_pop = 1'b0;
        check("unstall_still_push", exec_state, 4);
        @(negedge clk);
        check("unstall_written", exec_state, 0);
        drain("stall_results");

        // Underflow, clear, and clear colliding with a new error
        repeat (3) @(negedge clk);
        check("empty_rdy", ofifo_rdy, 0);
        check("empty_odata", odata, 0);
        ofifo_pop = 1'b1;
        @(negedge clk);
        ofifo_pop = 1'b0;
        check("udfl_set", udfl_err, 1);
        check("ovfl_sticky", ovfl_err, 1);
        err_clr   = 1'b1;
        ofifo_pop = 1'b1;
        @(negedge clk);
        ofifo_pop = 1'b0;
        check("clr_vs_udfl", udfl_err, 1);
        check("clr_ovfl", ovfl_err, 0);
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_udfl", udfl_err, 0);
        check("clr_ovfl_stays", ovfl_err, 0);

        // Reset mid-ACCUM with a result still buffered
        push_word(hdr(1, 0));
        push_word(8'h77);
        push_word(hdr(4, 2));
        push_word(8'h01);
        push_word(8'h02);
        ififo_push = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_state", exec_state, 2);
        check("pre_rst_rdy", ofifo_rdy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_state", exec_state, 0);
        check("async_rst_rdy", ofifo_rdy, 0);
        check("async_rst_odata", odata, 0);
        check("async_rst_not_full", ififo_not_full, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh packet after reset carries no residue
        exp_q.push_back(8'h55);
        push_word(hdr(2, 0));
        push_word(8'h5A);
        push_word(8'h0F);
        ififo_push = 1'b0;
        drain("post_rst_result");
        repeat (2) @(negedge clk);
        check("final_rdy", ofifo_rdy, 0);
        check("final_state", exec_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xorexec_multi.md
Name: xorexec_multi

Overview:
Parametrised successor to the single-mode XOR executor. Accepts packets on an input FIFO interface: one header word giving the opcode and operand count N, followed by N operands. Reduces the operands with the selected operation (XOR/AND/OR/ADD) and pushes one result word per packet into an output FIFO. It sits between a producer push interface and a consumer pop interface, and exports its FSM state for formal/coverage observation.

Parameters:
DWIDTH, 8, data word width; must be at least 4
IDEPTH, 8, input FIFO depth in words; must be a power of 2 and at least 2
ODEPTH, 4, output FIFO depth in words; must be a power of 2 and at least 2

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
ififo_push  in  1  write idata into the input FIFO
ififo_not_full  out  1  input FIFO has space; combinational from occupancy
idata  in  DWIDTH  input word (header or operand)
ofifo_pop  in  1  consume the odata word
ofifo_rdy  out  1  output FIFO is non-empty; odata is valid
odata  out  DWIDTH  head of output FIFO (first-word fall-through)
exec_state  out  3  FSM state encoding
err_clr  in  1  synchronous clear of the sticky error flags
ovfl_err  out  1  sticky: push was attempted while the input FIFO was full
udfl_err  out  1  sticky: pop was attempted while the output FIFO was empty

Behaviour:
- Reset is asynchronous and active-high, named rst; clock is clk. While rst is high:
  - both FIFOs are empty, so ififo_not_full=1, ofifo_rdy=0, odata=0;
  - exec_state=IDLE (0), accumulator=0, counter=0, ovfl_err=0, udfl_err=0.
  - A reset asserted mid-packet discards the partial packet and all buffered words.
- Header word format:
  - idata[1:0] selects the op: 0=XOR, 1=AND, 2=OR, 3=ADD (modulo 2^DWIDTH).
  - idata[DWIDTH-1:2] is the unsigned operand count N.
- Input FIFO:
  - A push with ififo_not_full=1 is written at the clock edge.
  - A push with ififo_not_full=0 is dropped and sets ovfl_err. This holds even if an internal pop occurs in the same cycle.
  - A written word is visible to the FSM the following cycle.
- Output FIFO:
  - odata is the registered head word.
  - A pop with ofifo_rdy=1 advances the FIFO. A pop with ofifo_rdy=0 is ignored and sets udfl_err.
  - A simultaneous FSM write and consumer pop on a non-empty, non-full FIFO keeps occupancy unchanged.
- Error flags: err_clr clears both flags. If err_clr and a new error occur in the same cycle, the flag remains set.
- FSM states and transitions:
  - IDLE (0): when the input FIFO is non-empty, pop the header, latch op and cnt=N, and set acc to the op identity (0 for XOR/OR/ADD, all-ones for AND). Go to ACCUM if N>0, or to PUSH if N=0 (the identity value becomes the result).
  - ACCUM (2): each cycle the input FIFO is non-empty, pop one operand, set acc = acc op data, and decrement cnt. When cnt==1 and a pop occurs, go to PUSH. When the input FIFO is empty, hold the state with no change.
  - PUSH (4): if the output FIFO is not full, write acc and go to IDLE. Otherwise stall in PUSH and hold acc.
  - Encodings 1, 3, 5-7 are unused; the FSM never enters them. If one is reached, the next state is IDLE.
- Throughput and latency:
  - One operand is consumed per cycle. Each packet adds one header cycle and at least one PUSH cycle.
  - With back-to-back pushes starting with the header at cycle 0, ofifo_rdy rises at cycle N+3.
  - The next packet's header is popped in the cycle after PUSH completes.
- Backpressure: ififo_not_full deasserts when IDEPTH words are buffered. The FSM never drops or reorders words.

Decomposition:
- Package xorexec_pkg contains:
  - op_e enum (XOR, AND, OR, ADD);
  - state_e enum (IDLE=0, ACCUM=2, PUSH=4);
  - the header field positions;
  - an identity(op) function and an apply(op, a, b) function.
- Sub-module xorexec_fifo: parametrised width/depth synchronous FIFO with FWFT head output, not_full and not_empty outputs, and asynchronous active-high reset.
- The top level instantiates xorexec_fifo twice, plus the FSM and accumulator.

Test Plan:
- Reset, then push header {N=3, XOR}, then 0x04, 0x0F, 0x30 back-to-back -> ofifo_rdy rises at cycle 6; odata=0x3B; exec_state sequence 0, 2, 2, 2, 4, 0.
- Header {N=0, AND} -> one result 0xFF after a single PUSH cycle. Header {N=2, ADD}, then 0xF0, 0x20 -> result 0x10 (wrap-around).
- Hold ofifo_pop=0 and send 5 packets with ODEPTH=4 -> 4 results buffered; FSM stalls in PUSH with exec_state=4. One pop -> the 5th result is written the next cycle.
- Push 9 words with IDEPTH=8 while the FSM is stalled -> 9th word dropped; ififo_not_full=0; ovfl_err=1. Pop on an empty output FIFO -> udfl_err=1. Assert err_clr -> both flags 0.
- Assert rst mid-ACCUM (2 of 4 operands consumed) -> all outputs return to reset values immediately. A fresh packet afterwards yields the correct result with no residue.
